// File: rtl/ctrl_shift_pipe_if.sv
// Bundle of control/status signals for ctrl_shift_pipe.
// master drives stall/flush/entry inputs and observes the taps; slave is the pipe.
interface ctrl_shift_pipe_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
);
    // No backpressure: an entry with in_valid=1 is captured on any edge where
    // stall=0 and flush does not squash stage 0; otherwise it is dropped.
    logic                     stall;
    logic                     flush;
    logic                     in_valid;
    logic [WIDTH-1:0]         in_data;
    logic [DEPTH*WIDTH-1:0]   tap_data;
    logic [DEPTH-1:0]         tap_valid;
    logic [WIDTH-1:0]         tail_data;
    logic                     tail_valid;
    logic                     busy;
    logic [15:0]              stall_cnt;
    logic [15:0]              flush_cnt;

    modport master (
        output stall, flush, in_valid, in_data,
        input  tap_data, tap_valid, tail_data, tail_valid, busy, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_data,
        output tap_data, tap_valid, tail_data, tail_valid, busy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_shift_pipe.sv
// Control shift pipeline with stall hold and partial flush of the youngest stages.
// Optional statistics counters are enabled by defining CTRL_SHIFT_PIPE_STATS_EN.
module ctrl_shift_pipe #(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 4,
    parameter int KILL_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    ctrl_shift_pipe_if.slave  bus
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            dat_d[i] = dat_q[i];
        end

        // Stage 0: squash beats stall beats load; invalid entries carry payload 0.
        if (bus.flush && (KILL_DEPTH > 0)) begin
            vld_d[0] = 1'b0;
            dat_d[0] = '0;
        end else if (!bus.stall) begin
            vld_d[0] = bus.in_valid;
            dat_d[0] = bus.in_valid ? bus.in_data : '0;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (bus.flush && (i < KILL_DEPTH)) begin
                vld_d[i] = 1'b0;
                dat_d[i] = '0;
            end else if (!bus.stall) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
        assign bus.tap_data[g*WIDTH +: WIDTH] = dat_q[g];
    end

    assign bus.tap_valid  = vld_q;
    assign bus.tail_data  = dat_q[DEPTH-1];
    assign bus.tail_valid = vld_q[DEPTH-1];
    assign bus.busy       = |vld_q;

`ifdef CTRL_SHIFT_PIPE_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (bus.flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
    assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ctrl_shift_pipe.sv
// Randomized scoreboard bench for ctrl_shift_pipe: two configurations driven in lockstep,
// (WIDTH=1,DEPTH=4,KILL_DEPTH=2) and (WIDTH=8,DEPTH=4,KILL_DEPTH=4).
module tb_ctrl_shift_pipe;

  localparam int D  = 4;
  localparam int EW = 4 + 32 + 1 + 8 + 1 + 16 + 16;

`ifdef CTRL_SHIFT_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;

  ctrl_shift_pipe_if #(.WIDTH(1), .DEPTH(D)) bus_a ();
  ctrl_shift_pipe_if #(.WIDTH(8), .DEPTH(D)) bus_b ();

  ctrl_shift_pipe #(.WIDTH(1), .DEPTH(D), .KILL_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  ctrl_shift_pipe #(.WIDTH(8), .DEPTH(D), .KILL_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each pipe is a list of entries, youngest first; -1 marks an empty slot.
  int pipe_m [2][D];
  int kill_m [2] = '{2, 4};
  int mask_m [2] = '{1, 255};
  int stall_cnt_m;
  int flush_cnt_m;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];

  int vectors;
  int miscompares;

  function automatic void model_step(int k, bit r, bit s, bit f, bit v, int d);
    int q[$];
    for (int j = 0; j < D; j++) q.push_back(pipe_m[k][j]);
    if (r) begin
      foreach (q[j]) q[j] = -1;
    end else begin
      if (!s) begin
        q.push_front(v ? (d & mask_m[k]) : -1);
        void'(q.pop_back());
      end
      if (f) begin
        for (int j = 0; j < kill_m[k]; j++) q[j] = -1;
      end
    end
    for (int j = 0; j < D; j++) pipe_m[k][j] = q[j];
  endfunction

  function automatic logic [EW-1:0] model_pack(int k);
    logic [3:0]  tv;
    logic [31:0] td;
    logic [7:0]  tl;
    int          w;
    w  = (k == 0) ? 1 : 8;
    tv = '0;
    td = '0;
    for (int j = 0; j < D; j++) begin
      if (pipe_m[k][j] >= 0) begin
        tv[j] = 1'b1;
        td    = td | (32'(pipe_m[k][j]) << (j * w));
      end
    end
    tl = (pipe_m[k][D-1] >= 0) ? 8'(pipe_m[k][D-1]) : 8'd0;
    return {tv, td, tv[D-1], tl, |tv, 16'(stall_cnt_m), 16'(flush_cnt_m)};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit s, input bit f, input bit v, input logic [7:0] d);
    @(negedge clk);
    rst            = r;
    bus_a.stall    = s;
    bus_a.flush    = f;
    bus_a.in_valid = v;
    bus_a.in_data  = d[0];
    bus_b.stall    = s;
    bus_b.flush    = f;
    bus_b.in_valid = v;
    bus_b.in_data  = d;
    model_step(0, r, s, f, v, int'(d));
    model_step(1, r, s, f, v, int'(d));
    if (r) begin
      stall_cnt_m = 0;
      flush_cnt_m = 0;
    end else begin
      if (STATS && s && stall_cnt_m < 65535) stall_cnt_m++;
      if (STATS && f && flush_cnt_m < 65535) flush_cnt_m++;
    end
    exp_a_q.push_back(model_pack(0));
    exp_b_q.push_back(model_pack(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- monitor / scoreboard ----------------
  function automatic void check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got tv=%b td=%h tlv=%b tld=%h busy=%b sc=%h fc=%h required tv=%b td=%h tlv=%b tld=%h busy=%b sc=%h fc=%h",
               name, $time,
               act[77:74], act[73:42], act[41], act[40:33], act[32], act[31:16], act[15:0],
               exp[77:74], exp[73:42], exp[41], exp[40:33], exp[32], exp[31:16], exp[15:0]);
    end
  endfunction

  initial begin
    logic [EW-1:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() > 0) begin
        act = {bus_a.tap_valid, 28'd0, bus_a.tap_data, bus_a.tail_valid, 7'd0, bus_a.tail_data,
               bus_a.busy, bus_a.stall_cnt, bus_a.flush_cnt};
        check("pipe_a", act, exp_a_q.pop_front());
      end
      if (exp_b_q.size() > 0) begin
        act = {bus_b.tap_valid, bus_b.tap_data, bus_b.tail_valid, bus_b.tail_data,
               bus_b.busy, bus_b.stall_cnt, bus_b.flush_cnt};
        check("pipe_b", act, exp_b_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    vectors     = 0;
    miscompares = 0;
    stall_cnt_m = 0;
    flush_cnt_m = 0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < D; j++) pipe_m[k][j] = -1;
    rst            = 1'b1;
    bus_a.stall    = 1'b0;
    bus_a.flush    = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_b.stall    = 1'b0;
    bus_b.flush    = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;

    // Reset with garbage on the inputs.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);

    // Single pulse travels to the tail.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    idle(6);

    // Pulse held in stage 1 by a 3-cycle stall.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hEE);
    idle(5);

    // Full pipe then flush without stall.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hD5);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hE7);
    idle(4);

    // Full pipe then flush with stall.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h35);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h47);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h59);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);

    // Pattern 4'b1011 then reset while stalled.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h81);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h93);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB7);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hC9);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hDB);
    idle(5);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    end
    idle(5);

    // Long stall run to reach counter saturation, then release and a few flushes.
    for (int i = 0; i < 70000; i++) begin
      drive(1'b0, 1'b1, ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) == 0), 1'b1,
            8'($urandom_range(0, 255)));
    end
    idle(3);

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while ((exp_a_q.size() > 0 || exp_b_q.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    vectors++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d/%0d pending required 0/0", exp_a_q.size(), exp_b_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_shift_pipe.md
CTRL_SHIFT_PIPE -- requirements
Module: ctrl_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each control entry (1..32).
REQ-002 Parameter DEPTH, default 4, number of pipeline stages (2..16).
REQ-003 Parameter KILL_DEPTH, default 2, number of youngest stages squashed by flush (1..DEPTH).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset rst, synchronous, active-high.
REQ-006 stall  input  1  active-high hold; stages do not advance.
REQ-007 flush  input  1  active-high squash of stages 0..KILL_DEPTH-1 (jump/branch redirect).
REQ-008 in_valid  input  1  entry presented to stage 0 is valid.
REQ-009 in_data  input  WIDTH  entry payload for stage 0.
REQ-010 tap_data  output  DEPTH*WIDTH  all stage payloads; stage i at bits [i*WIDTH +: WIDTH].
REQ-011 tap_valid  output  DEPTH  valid bit per stage; bit i = stage i.
REQ-012 tail_data  output  WIDTH  stage DEPTH-1 payload (equals tap slice DEPTH-1).
REQ-013 tail_valid  output  1  stage DEPTH-1 valid.
REQ-014 busy  output  1  OR of all tap_valid bits.
REQ-015 stall_cnt  output  16  stall-cycle counter (see Configuration).
REQ-016 flush_cnt  output  16  flush-event counter (see Configuration).

Function
REQ-017 Every output SHALL be registered or a pure combinational function of registered state; no input-to-output combinational path.
REQ-018 With stall=0 and flush=0: stage0 <= {in_valid, in_data}; stage i <= stage i-1 for i=1..DEPTH-1; latency in_data to tail_data = DEPTH cycles.
REQ-019 With stall=1 and flush=0: all stages SHALL hold their value; in_data is dropped.
REQ-020 With flush=1 and stall=0: stages 0..KILL_DEPTH-1 SHALL become invalid with payload 0; stages KILL_DEPTH..DEPTH-1 SHALL shift normally (stage KILL_DEPTH receives old stage KILL_DEPTH-1).
REQ-021 With flush=1 and stall=1: stages 0..KILL_DEPTH-1 SHALL become invalid with payload 0; all other stages hold; flush takes priority over stall for squashed stages.
REQ-022 A stage whose valid bit is 0 SHALL present payload 0 on tap_data; in_valid=0 loads payload 0 regardless of in_data.
REQ-023 KILL_DEPTH=DEPTH SHALL squash the whole pipe, with nothing shifting out.
REQ-024 busy SHALL update in the same cycle as the valid bits it reflects.

Reset
REQ-025 rst=1 SHALL clear all stage valid bits and payloads to 0, regardless of stall/flush, including every intermediate stage.
REQ-026 After reset: tap_valid=0, tap_data=0, tail_valid=0, busy=0, stall_cnt=0, flush_cnt=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight entries on the next edge; the first valid output after release requires DEPTH shift cycles.

Configuration
REQ-028 Macro CTRL_SHIFT_PIPE_STATS_EN SHALL gate the statistics counters.
REQ-029 Defined: stall_cnt increments on each non-reset cycle with stall=1; flush_cnt increments on each non-reset cycle with flush=1; both saturate at 16'hFFFF.
REQ-030 Undefined: stall_cnt and flush_cnt SHALL be constant 0, with no counter flops; ports remain present.

Verification (WIDTH=1, DEPTH=4, KILL_DEPTH=2 unless noted)
REQ-031 Reset, then in_valid=1, in_data=1 for one cycle, idle after -> tail_valid=1, tail_data=1 exactly 4 cycles later, for one cycle; busy=1 for 4 cycles.
REQ-032 Pulse entered, stall=1 for 3 cycles while the entry sits in stage 1 -> tap_valid stays 4'b0010 during stall; tail_valid is reached 3 cycles later than without stall.
REQ-033 Entries A,B,C,D loaded on consecutive cycles (tap_valid=4'b1111), then flush=1, stall=0 -> next tap_valid=4'b1100, with stage 2 = old stage 1 (C) and stage 3 = old stage 2 (B).
REQ-034 tap_valid=4'b1111, then flush=1 and stall=1 -> tap_valid=4'b1100, stages 2 and 3 unchanged; KILL_DEPTH=4 flush -> tap_valid=4'b0000, busy=0 next cycle.
REQ-035 rst asserted with tap_valid=4'b1011 and stall=1 -> next cycle all outputs 0; with STATS_EN, 70000 stall cycles -> stall_cnt=16'hFFFF, and the macro undefined -> stall_cnt=0 throughout.
